// File: rtl/mem_wb_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage_pipe
//  Description : MEM->WB pipeline stage built as a 2-entry skid FIFO.
//                Each entry holds {write-enable, destination, write data}.
//                The write data is chosen between memory and ALU at capture.
//                The stage presents the head entry to the register file and
//                forwards the youngest pending register write.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage_pipe #(
    parameter int DATA_W       = 24,
    parameter int DEST_W       = 4,
    parameter int ZERO_DEST_WB = 1
) (
    input  logic              clk,
    input  logic              rst,
    // MEM-side entry
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              writeback_enable,
    input  logic              mem_read_enable,
    input  logic [DEST_W-1:0] instruction_dest,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic [DATA_W-1:0] alu_result,
    // Control
    input  logic              flush,
    // Register-file side
    input  logic              out_ready,
    output logic              out_valid,
    output logic              writeback_enable_out,
    output logic [DEST_W-1:0] instruction_dest_out,
    output logic [DATA_W-1:0] writeback_data_out,
    // Forwarding
    output logic              fwd_valid,
    output logic [DEST_W-1:0] fwd_dest,
    output logic [DATA_W-1:0] fwd_data,
    // Status
    output logic [1:0]        occupancy
);

    localparam logic [1:0] c_CNT_EMPTY = 2'd0;
    localparam logic [1:0] c_CNT_FULL  = 2'd2;
    localparam logic       c_ZERO_SUPP = (ZERO_DEST_WB != 0);

    // ------------------------------------------------------------------
    // Storage and bookkeeping
    // ------------------------------------------------------------------
    logic [1:0]        r_we;
    logic [DEST_W-1:0] r_dest [0:1];
    logic [DATA_W-1:0] r_data [0:1];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_count;

    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_cap_data;
    logic              w_head_valid;
    logic              w_head_we;
    logic [DEST_W-1:0] w_head_dest;
    logic [DATA_W-1:0] w_head_data;
    logic              w_tail_ptr;
    logic              w_src_found;
    logic              w_src_ptr;
    logic              w_src_zero;

    // Handshake: in_ready depends only on the registered count so that no
    // combinational path runs from out_ready back to the upstream stage.
    always_comb begin
        in_ready     = (r_count != c_CNT_FULL);
        w_head_valid = (r_count != c_CNT_EMPTY);
        w_push       = in_valid && in_ready && !flush;
        w_pop        = w_head_valid && out_ready && !flush;
        w_cap_data   = mem_read_enable ? mem_read_data : alu_result;
    end

    // Head-entry outputs, gated to zero whenever the stage is empty.
    always_comb begin
        w_head_we   = r_we[r_rd_ptr];
        w_head_dest = r_dest[r_rd_ptr];
        w_head_data = r_data[r_rd_ptr];

        out_valid            = w_head_valid;
        writeback_enable_out = w_head_valid && w_head_we &&
                               !(c_ZERO_SUPP && (w_head_dest == '0));
        instruction_dest_out = w_head_valid ? w_head_dest : '0;
        writeback_data_out   = w_head_valid ? w_head_data : '0;
    end

    // Forwarding picks the youngest held entry that writes the register file;
    // with two entries the tail (the one behind the head) is the youngest.
    always_comb begin
        w_tail_ptr  = ~r_rd_ptr;
        w_src_found = 1'b0;
        w_src_ptr   = r_rd_ptr;
        if ((r_count == c_CNT_FULL) && r_we[w_tail_ptr]) begin
            w_src_found = 1'b1;
            w_src_ptr   = w_tail_ptr;
        end else if (w_head_valid && r_we[r_rd_ptr]) begin
            w_src_found = 1'b1;
            w_src_ptr   = r_rd_ptr;
        end
        w_src_zero = c_ZERO_SUPP && (r_dest[w_src_ptr] == '0);

        fwd_valid = w_src_found && !w_src_zero;
        fwd_dest  = fwd_valid ? r_dest[w_src_ptr] : '0;
        fwd_data  = fwd_valid ? r_data[w_src_ptr] : '0;
    end

    assign occupancy = r_count;

    // Pointer and count update; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= c_CNT_EMPTY;
        end else if (flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= c_CNT_EMPTY;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry capture; reset clears the entry registers, flush only drops them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we <= '0;
            for (int i = 0; i < 2; i++) begin
                r_dest[i] <= '0;
                r_data[i] <= '0;
            end
        end else if (w_push) begin
            r_we[r_wr_ptr]   <= writeback_enable;
            r_dest[r_wr_ptr] <= instruction_dest;
            r_data[r_wr_ptr] <= w_cap_data;
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage_pipe.md
MEM_WB_STAGE_PIPE -- requirements
Module: mem_wb_stage_pipe

Interface
REQ-001 Parameter DATA_W, default 24, width of data paths (alu_result, mem_read_data, writeback_data_out, fwd_data).
REQ-002 Parameter DEST_W, default 4, width of destination register index.
REQ-003 Parameter ZERO_DEST_WB, default 1, 1 = writes to destination 0 are suppressed at output.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  MEM-side entry presented this cycle.
REQ-007 in_ready  output  1  stage can accept an entry this cycle.
REQ-008 writeback_enable  input  1  entry writes register file.
REQ-009 mem_read_enable  input  1  entry's result comes from memory, else ALU.
REQ-010 instruction_dest  input  DEST_W  destination register index.
REQ-011 mem_read_data  input  DATA_W  memory read result.
REQ-012 alu_result  input  DATA_W  ALU result.
REQ-013 flush  input  1  discard all held entries.
REQ-014 out_ready  input  1  register file accepts head entry this cycle.
REQ-015 out_valid  output  1  head entry valid.
REQ-016 writeback_enable_out  output  1  qualified write strobe for head entry.
REQ-017 instruction_dest_out  output  DEST_W  head entry destination.
REQ-018 writeback_data_out  output  DATA_W  head entry write data.
REQ-019 fwd_valid  output  1  forwarding candidate available.
REQ-020 fwd_dest  output  DEST_W  forwarding destination index.
REQ-021 fwd_data  output  DATA_W  forwarding data.
REQ-022 occupancy  output  2  entries held, 0..2.

Function
REQ-023 Storage: 2-entry FIFO; each entry {we, dest, data}; data = mem_read_enable ? mem_read_data : alu_result, selected at capture.
REQ-024 in_ready = (occupancy != 2); combinational from registered count only, no path from out_ready.
REQ-025 Push when in_valid && in_ready && !flush; pop when out_valid && out_ready && !flush.
REQ-026 Push and pop same cycle at occupancy 1: count stays 1, new entry becomes head next cycle.
REQ-027 Push at occupancy 0: out_valid rises next cycle (latency 1 cycle, input to output).
REQ-028 in_valid with in_ready=0: entry not captured, no state change; upstream holds inputs.
REQ-029 out_valid = (occupancy != 0); head outputs driven directly from entry registers.
REQ-030 writeback_enable_out = out_valid && head.we && !(ZERO_DEST_WB && head.dest == 0).
REQ-031 When out_valid=0, writeback_enable_out=0; instruction_dest_out and writeback_data_out = 0.
REQ-032 Head held stable while out_valid && !out_ready (no change until popped or flushed).
REQ-033 Forwarding source = youngest held entry with we=1 (tail entry if its we=1, else head if its we=1); fwd_valid=0 if none or dest==0 with ZERO_DEST_WB=1.
REQ-034 fwd_dest/fwd_data = 0 when fwd_valid=0.
REQ-035 flush: next cycle occupancy=0, out_valid=0; flush overrides push and pop in same cycle.
REQ-036 Pointers wrap modulo 2; count never exceeds 2 or underflows below 0.

Reset
REQ-037 rst high at rising edge: occupancy=0, pointers=0, entry registers cleared; rst overrides flush, push, pop.
REQ-038 After reset: out_valid=0, writeback_enable_out=0, fwd_valid=0, all data/dest outputs 0, in_ready=1.
REQ-039 Reset asserted mid-stall discards all held entries; no write strobe until a new push.

Verification
REQ-040 Single ALU op: push we=1, mem_read_enable=0, dest=5, alu_result=0x00ABCD, out_ready=1 -> next cycle out_valid=1, writeback_enable_out=1, dest_out=5, data_out=0x00ABCD; following cycle out_valid=0.
REQ-041 Load select: push mem_read_enable=1, mem_read_data=0x123456, alu_result=0x000010, dest=3 -> writeback_data_out=0x123456.
REQ-042 Backpressure: out_ready=0, push 3 consecutive entries -> occupancy 1,2,2; in_ready=0 from the cycle after the second push; third entry not captured; release out_ready -> entries 1,2 retire in order.
REQ-043 Forwarding: hold out_ready=0, push dest=2 data=0x111111, then dest=2 data=0x222222 -> fwd_valid=1, fwd_dest=2, fwd_data=0x222222.
REQ-044 Zero dest: push we=1 dest=0 with ZERO_DEST_WB=1 -> out_valid=1, writeback_enable_out=0, fwd_valid=0.
REQ-045 Flush vs push: occupancy 2, assert flush with in_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1; reset mid-stall -> same result.
